// File: rtl/mini_core_param.sv
// mini_core_param: 16-bit instruction, multi-cycle (FETCH/DECODE/EXEC/WB) core
// with a 16-entry register file, writable instruction memory and debug read port.
module mini_core_param #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned IMEM_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_waddr,
  input  logic [15:0]        imem_wdata,
  input  logic [3:0]         dbg_sel,
  output logic               busy,
  output logic               halted,
  output logic [IMEM_AW-1:0] pc,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [15:0]        retired
);

  localparam int unsigned IMEM_DEPTH = 1 << IMEM_AW;
  localparam int unsigned NUM_REGS   = 16;
  localparam int unsigned INSTR_W    = 16;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_BEQZ = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t state;
  state_t state_next;

  logic [INSTR_W-1:0] imem [IMEM_DEPTH];
  logic [DATA_W-1:0]  regs [NUM_REGS];

  logic [INSTR_W-1:0] ir;
  logic [3:0]         op;
  logic [3:0]         ra;
  logic [3:0]         rb;
  logic [3:0]         rc;
  logic [7:0]         imm;

  logic [DATA_W-1:0]  a_val;
  logic [DATA_W-1:0]  b_val;
  logic [DATA_W-1:0]  c_val;

  logic [DATA_W-1:0]  alu_result;
  logic               alu_we;
  logic [IMEM_AW-1:0] pc_calc;

  logic [DATA_W-1:0]  result;
  logic               result_we;
  logic [IMEM_AW-1:0] pc_new;

  assign op  = ir[15:12];
  assign ra  = ir[11:8];
  assign rb  = ir[7:4];
  assign rc  = ir[3:0];
  assign imm = ir[7:0];

  assign dbg_data = regs[dbg_sel];

  // State register plus registered status flags derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      busy   <= (state_next inside {S_FETCH, S_DECODE, S_EXEC, S_WB});
      halted <= (state_next == S_HALT);
    end
  end

  // Next-state logic: one pass through FETCH..WB per instruction
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_HALT: if (start) state_next = S_FETCH;
      S_FETCH:        state_next = S_DECODE;
      S_DECODE:       state_next = S_EXEC;
      S_EXEC:         state_next = S_WB;
      S_WB:           state_next = (op == OP_HALT) ? S_HALT : S_FETCH;
      default:        state_next = S_IDLE;
    endcase
  end

  // Instruction memory write port, locked out while an instruction is in flight
  always_ff @(posedge clk) begin
    if (imem_we && !busy) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  // Execute stage: ALU result, write enable and next pc for the latched instruction
  always_comb begin
    alu_result = '0;
    alu_we     = 1'b0;
    pc_calc    = pc + IMEM_AW'(1);
    case (op)
      OP_LDI: begin
        alu_result = DATA_W'(imm);
        alu_we     = 1'b1;
      end
      OP_ADD: begin
        alu_result = b_val + c_val;
        alu_we     = 1'b1;
      end
      OP_SUB: begin
        alu_result = b_val - c_val;
        alu_we     = 1'b1;
      end
      OP_AND: begin
        alu_result = b_val & c_val;
        alu_we     = 1'b1;
      end
      OP_OR: begin
        alu_result = b_val | c_val;
        alu_we     = 1'b1;
      end
      OP_XOR: begin
        alu_result = b_val ^ c_val;
        alu_we     = 1'b1;
      end
      OP_BEQZ: if (a_val == '0) pc_calc = IMEM_AW'(imm);
      OP_JMP:  pc_calc = IMEM_AW'(imm);
      OP_HALT: pc_calc = pc;
      default: ;
    endcase
  end

  // Datapath: fetch, operand latch, execute latch and write-back/retire
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= '0;
      ir        <= '0;
      a_val     <= '0;
      b_val     <= '0;
      c_val     <= '0;
      result    <= '0;
      result_we <= 1'b0;
      pc_new    <= '0;
      retired   <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE, S_HALT: if (start) pc <= '0;
        S_FETCH:        ir <= imem[pc];
        S_DECODE: begin
          a_val <= regs[ra];
          b_val <= regs[rb];
          c_val <= regs[rc];
        end
        S_EXEC: begin
          result    <= alu_result;
          result_we <= alu_we;
          pc_new    <= pc_calc;
        end
        S_WB: begin
          if (result_we) regs[ra] <= result;
          pc <= pc_new;
          if (retired != 16'hFFFF) retired <= retired + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_core_param.sv
// Scoreboard bench for mini_core_param: an ISA-level interpreter predicts the
// architectural state at each HALT; a monitor checks it when halted rises.
module tb_mini_core_param;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned MOD   = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [15:0]   imem_wdata;
  logic [3:0]    dbg_sel;
  logic          busy;
  logic          halted;
  logic [AW-1:0] pc;
  logic [DW-1:0] dbg_data;
  logic [15:0]   retired;

  mini_core_param #(.DATA_W(DW), .IMEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .dbg_sel(dbg_sel),
    .busy(busy), .halted(halted), .pc(pc), .dbg_data(dbg_data), .retired(retired)
  );

  always #20 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic            chk_cyc;
    logic [31:0]     cyc;
    logic            busy;
    logic            halted;
    logic [15:0]     retired;
    logic            chk_pc;
    logic [AW-1:0]   pc;
    logic            chk_regs;
    logic [16*DW-1:0] regs;
  } exp_t;

  exp_t halt_q[$];
  exp_t snap_q[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned mon_done = 0;
  int unsigned snap_req = 0;
  int unsigned pushed   = 0;

  logic       mon_act = 1'b0;
  logic [3:0] mon_sel = 4'd0;
  assign dbg_sel = mon_act ? mon_sel : 4'd0;

  // Reference model: architectural state and program image
  int unsigned m_regs [16];
  int unsigned m_ret;
  logic [15:0] m_prog [16];
  int unsigned m_n;

  function automatic logic [15:0] ins(input int unsigned o, a, b, c);
    return {4'(o), 4'(a), 4'(b), 4'(c)};
  endfunction

  function automatic logic [15:0] ldi(input int unsigned a, v);
    return {4'h1, 4'(a), 8'(v)};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 0;
    m_ret = 0;
  endfunction

  // Interpret the program from address 0 until HALT
  function automatic void run_model();
    int unsigned p, o, a, b, c, im, nxt;
    bit done;
    logic [15:0] w;
    p = 0; done = 0; m_n = 0;
    while (!done && m_n < 1000) begin
      w   = m_prog[p];
      o   = 32'(w[15:12]);
      a   = 32'(w[11:8]);
      b   = 32'(w[7:4]);
      c   = 32'(w[3:0]);
      im  = 32'(w[7:0]);
      nxt = (p + 1) % DEPTH;
      case (o)
        1:  m_regs[a] = im % MOD;
        2:  m_regs[a] = (m_regs[b] + m_regs[c]) % MOD;
        3:  m_regs[a] = (m_regs[b] + MOD - m_regs[c]) % MOD;
        4:  m_regs[a] = m_regs[b] & m_regs[c];
        5:  m_regs[a] = m_regs[b] | m_regs[c];
        6:  m_regs[a] = m_regs[b] ^ m_regs[c];
        7:  if (m_regs[a] == 0) nxt = im % DEPTH;
        8:  nxt = im % DEPTH;
        15: done = 1;
        default: ;
      endcase
      m_n++;
      m_ret = (m_ret < 65535) ? m_ret + 1 : 65535;
      p = nxt;
    end
  endfunction

  function automatic exp_t mk_exp(input bit ccyc, input int unsigned ecyc, input bit eb, eh,
                                  input int unsigned eret, input bit cpc, input int unsigned epc,
                                  input bit cregs);
    exp_t e;
    e.chk_cyc  = ccyc;
    e.cyc      = 32'(ecyc);
    e.busy     = eb;
    e.halted   = eh;
    e.retired  = 16'(eret);
    e.chk_pc   = cpc;
    e.pc       = AW'(epc);
    e.chk_regs = cregs;
    for (int i = 0; i < 16; i++) e.regs[i*DW +: DW] = DW'(m_regs[i]);
    return e;
  endfunction

  task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s[%0d] at cycle %0d: got 0x%0h, expected 0x%0h", nm, idx, cyc, act, expv);
    end
  endtask

  // Monitor: on halted rising or a snapshot request, pop and compare
  initial begin : monitor
    logic prev_h;
    bit is_snap, hit, empty;
    int unsigned seen;
    exp_t e;
    prev_h = 1'b0;
    seen   = 0;
    forever begin
      @(negedge clk);
      is_snap = (snap_req != seen);
      hit     = is_snap || (halted && !prev_h);
      prev_h  = halted;
      if (hit) begin
        if (is_snap) seen = snap_req;
        empty = is_snap ? (snap_q.size() == 0) : (halt_q.size() == 0);
        if (empty) begin
          cmp("unexpected_event", 0, 32'(halted), 32'(0));
        end else begin
          if (is_snap) e = snap_q.pop_front();
          else         e = halt_q.pop_front();
          if (e.chk_cyc) cmp("halt_cycle", 0, 32'(cyc), e.cyc);
          cmp("busy", 0, 32'(busy), 32'(e.busy));
          cmp("halted", 0, 32'(halted), 32'(e.halted));
          cmp("retired", 0, 32'(retired), 32'(e.retired));
          if (e.chk_pc) cmp("pc", 0, 32'(pc), 32'(e.pc));
          if (e.chk_regs) begin
            mon_act = 1'b1;
            for (int i = 0; i < 16; i++) begin
              mon_sel = 4'(i);
              #1;
              cmp("reg", i, 32'(dbg_data), 32'(e.regs[i*DW +: DW]));
            end
            mon_act = 1'b0;
          end
        end
        mon_done++;
      end
    end
  end

  task automatic wait_sb();
    int unsigned k;
    k = 0;
    while (mon_done < pushed && k < 600) begin
      @(negedge clk);
      k++;
    end
    if (mon_done < pushed) begin
      $display("FAIL sb_timeout: %0d responses seen, %0d required", mon_done, pushed);
      $fatal(1, "scoreboard timeout");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic load_imem();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      imem_we    = 1'b1;
      imem_waddr = AW'(i);
      imem_wdata = m_prog[i];
    end
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  task automatic issue_start(input bit expect_halt, input bit with_wr,
                             input logic [AW-1:0] wa, input logic [15:0] wd);
    @(negedge clk);
    if (with_wr) begin
      imem_we    = 1'b1;
      imem_waddr = wa;
      imem_wdata = wd;
      m_prog[wa] = wd;
    end
    start = 1'b1;
    if (expect_halt) begin
      run_model();
      halt_q.push_back(mk_exp(1, cyc + 1 + 4 * m_n, 0, 1, m_ret, 0, 0, 1));
      pushed++;
    end
    @(negedge clk);
    start   = 1'b0;
    imem_we = 1'b0;
  endtask

  task automatic snapshot(input bit eb, eh, input int unsigned eret, epc, input bit cregs);
    @(posedge clk);
    #2;
    snap_q.push_back(mk_exp(0, 0, eb, eh, eret, 1, epc, cregs));
    pushed++;
    snap_req++;
    wait_sb();
  endtask

  task automatic prog_clear();
    for (int i = 0; i < 16; i++) m_prog[i] = 16'h0000;
  endtask

  task automatic prog_basic();
    prog_clear();
    m_prog[0] = ldi(1, 5);
    m_prog[1] = ldi(2, 3);
    m_prog[2] = ins(2, 3, 1, 2);
    m_prog[3] = 16'hF000;
  endtask

  // Stimulus
  initial begin : stim
    int unsigned r, tgt;
    rst = 1'b1; start = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    snapshot(0, 0, 0, 0, 1);

    // Basic program, then restart from HALT keeps registers and count
    prog_basic();
    load_imem();
    issue_start(1, 0, '0, '0);
    wait_sb();
    issue_start(1, 0, '0, '0);
    wait_sb();

    // Reset during EXEC of the ADD abandons it; a fresh start re-runs
    do_reset();
    load_imem();
    issue_start(0, 0, '0, '0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    snapshot(0, 0, 0, 0, 1);
    issue_start(1, 0, '0, '0);
    wait_sb();

    // Writes and start pulses while busy are ignored
    do_reset();
    load_imem();
    issue_start(1, 0, '0, '0);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j % 2 == 0) begin
        imem_we = 1'b1; imem_waddr = '0; imem_wdata = 16'hF000; start = 1'b1;
      end else begin
        imem_we = 1'b0; start = 1'b0;
      end
    end
    repeat (2) @(posedge clk);
    snapshot(1, 0, 2, 2, 0);
    issue_start(1, 0, '0, '0);
    wait_sb();

    // 8-bit wrap arithmetic; slot 0 written on the same edge as start
    do_reset();
    prog_clear();
    m_prog[0] = 16'hF000;
    m_prog[1] = ldi(2, 1);
    m_prog[2] = ins(2, 3, 1, 2);
    m_prog[3] = ins(3, 4, 2, 1);
    m_prog[4] = 16'hF000;
    load_imem();
    issue_start(1, 1, '0, ldi(1, 8'hFF));
    wait_sb();

    // Countdown loop with BEQZ/JMP
    prog_clear();
    m_prog[0] = ldi(1, 3);
    m_prog[1] = ldi(2, 1);
    m_prog[2] = ins(3, 1, 1, 2);
    m_prog[3] = {4'h7, 4'd1, 8'd5};
    m_prog[4] = {4'h8, 4'd0, 8'd2};
    m_prog[5] = 16'hF000;
    load_imem();
    issue_start(1, 0, '0, '0);
    wait_sb();

    // pc wrap 15 -> 0 falls back into the program at address 0
    do_reset();
    prog_clear();
    m_prog[0] = {4'h7, 4'd7, 8'd3};
    m_prog[1] = 16'hF000;
    m_prog[3] = ldi(7, 1);
    m_prog[4] = {4'h8, 4'd0, 8'd14};
    load_imem();
    issue_start(1, 0, '0, '0);
    wait_sb();

    // Random forward-branching programs
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 3) == 0) do_reset();
      for (int i = 0; i < 15; i++) begin
        r   = $urandom_range(0, 9);
        tgt = $urandom_range(15, i + 1);
        case (r)
          0, 1:    m_prog[i] = ldi($urandom_range(0, 15), ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255));
          2, 3, 4, 5, 6:
                   m_prog[i] = ins($urandom_range(2, 6), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
          7:       m_prog[i] = {4'($urandom_range(9, 14)), 12'($urandom)};
          8:       m_prog[i] = {4'h7, 4'($urandom_range(0, 15)), 8'(tgt)};
          default: m_prog[i] = {4'h8, 4'($urandom), 8'(tgt)};
        endcase
      end
      m_prog[15] = {4'hF, 12'($urandom)};
      load_imem();
      issue_start(1, 0, '0, '0);
      wait_sb();
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
